// File: rtl/seq_shifter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seq_shifter
//   Iterative shift unit that moves the operand one bit position per clock.
//   It provides logical right shift, left shift and rotate left, which are the
//   opposite-direction operations to the combinational datapath shifter.
//   Decode issues requests on the in_valid/in_ready side and writeback takes
//   results on the out_valid/out_ready side. Only one request is in flight.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : request valid
//   in_ready  : unit can accept a request (high only in IDLE)
//   opcode    : 00 SRL, 01 SLL, 10 ROL, 11 pass-through
//   a         : operand
//   b         : shift amount source, only b[SHAMT_W-1:0] is used
//   out_valid : result valid (high only in DONE)
//   out_ready : consumer accepts result
//   result    : shifted value, held stable while out_valid is high
//   busy      : high in SHIFT or DONE
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    localparam logic [1:0] OP_SRL  = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_ROL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [SHAMT_W-1:0] SHAMT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] SHAMT_ONE  = SHAMT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   next_work;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] shamt_in;

    // The upper bits of b carry no meaning for this unit.
    logic unused_b_high;
    assign unused_b_high = ^b[WIDTH-1:SHAMT_W];

    assign shamt_in = b[SHAMT_W-1:0];

    // One-bit step of the latched operation applied to the work register.
    always_comb begin
        next_work = work;
        case (op)
            OP_SRL:  next_work = {1'b0, work[WIDTH-1:1]};
            OP_SLL:  next_work = {work[WIDTH-2:0], 1'b0};
            OP_ROL:  next_work = {work[WIDTH-2:0], work[WIDTH-1]};
            default: next_work = work;
        endcase
    end

    // Control FSM with registered handshake outputs. The result register is
    // loaded on the edge that enters DONE, so it is already stable in the
    // first cycle out_valid is seen and cannot change until DONE is left.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            work      <= '0;
            count     <= '0;
            op        <= OP_SRL;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= opcode;
                        work     <= a;
                        count    <= shamt_in;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        // Nothing to iterate: the operand is the answer.
                        if (shamt_in == SHAMT_ZERO || opcode == OP_PASS) begin
                            state     <= DONE;
                            result    <= a;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    work  <= next_work;
                    count <= count - SHAMT_ONE;
                    if (count == SHAMT_ONE) begin
                        state     <= DONE;
                        result    <= next_work;
                        out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_seq_shifter
//   Scoreboard bench for seq_shifter. The driver pushes each request's
//   hand-computed result and latency when the request is accepted; a separate
//   monitor pops and compares whenever out_valid first rises, and checks that
//   result stays put for as long as out_valid is held.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  opcode = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        busy;

    seq_shifter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: event did not occur within its bound", name);
    endtask

    // Present a request and hold it until accepted. lat is the number of
    // rising edges, counting the accept edge, until out_valid is seen.
    task automatic applyStimulus(input string name, input logic [1:0] op,
                                 input logic [15:0] av, input logic [15:0] bv,
                                 input logic [15:0] exp_res, input int lat);
        int waited;
        @(negedge clk);
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            reportFail({name, " accept"});
            in_valid = 1'b0;
        end else begin
            sb.push_back('{exp_res, lat, cycle + 1, name});
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            reportFail({name, " drain"});
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compares on the first cycle of each out_valid, then checks hold.
    logic        prev_valid = 1'b0;
    logic [15:0] held_result = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else if (out_valid) begin
            if (!prev_valid) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected out_valid: result 0x%0h, no request outstanding", result);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, " result"}, 32'(result), 32'(e.res));
                    checkOutput({e.name, " latency"}, 32'(cycle - e.acc + 1), 32'(e.lat));
                end
                held_result = result;
            end else begin
                checkOutput("result hold", 32'(result), 32'(held_result));
            end
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int pulses;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset result", 32'(result), 32'h0);
        rst_n = 1'b1;

        // Directed vectors: name, op, a, b, expected result, latency
        applyStimulus("srl 8001>>4",   2'b00, 16'h8001, 16'h0004, 16'h0800, 5);
        applyStimulus("rol 8001<<1",   2'b10, 16'h8001, 16'h0001, 16'h0003, 2);
        applyStimulus("rol 1234 by15", 2'b10, 16'h1234, 16'h000F, 16'h091A, 16);
        applyStimulus("sll 00f0 b=fff8", 2'b01, 16'h00F0, 16'hFFF8, 16'hF000, 9);
        applyStimulus("srl beef by0",  2'b00, 16'hBEEF, 16'h0000, 16'hBEEF, 1);
        applyStimulus("pass 1234",     2'b11, 16'h1234, 16'h000F, 16'h1234, 1);
        applyStimulus("srl ffff>>1",   2'b00, 16'hFFFF, 16'h0001, 16'h7FFF, 2);
        applyStimulus("srl 8000>>15",  2'b00, 16'h8000, 16'h000F, 16'h0001, 16);
        applyStimulus("sll 0001<<15",  2'b01, 16'h0001, 16'h000F, 16'h8000, 16);
        applyStimulus("rol f00f by4",  2'b10, 16'hF00F, 16'h0004, 16'h00FF, 5);
        waitDrain("directed");

        // Backpressure: result held while a new request waits upstream
        out_ready = 1'b0;
        applyStimulus("bp srl", 2'b00, 16'h8001, 16'h0004, 16'h0800, 5);
        fork
            applyStimulus("bp sll", 2'b01, 16'h0003, 16'h0002, 16'h000C, 3);
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (!out_valid) reportFail("bp out_valid");
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bp in_ready", 32'(in_ready), 32'd0);
                    checkOutput("bp busy", 32'(busy), 32'd1);
                    checkOutput("bp out_valid", 32'(out_valid), 32'd1);
                    checkOutput("bp result", 32'(result), 32'h0800);
                end
                out_ready = 1'b1;
                @(negedge clk);
                checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
                checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
            end
        join
        waitDrain("backpressure");

        // Reset in the middle of a shift discards the request
        applyStimulus("rst sll", 2'b01, 16'h0001, 16'h000A, 16'h0400, 11);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst result", 32'(result), 32'h0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checkOutput("rst no out_valid pulse", 32'(pulses), 32'd0);

        // Unit recovers after reset
        applyStimulus("post-rst rol", 2'b10, 16'h8001, 16'h0001, 16'h0003, 2);
        waitDrain("post-reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle iterative shift unit. Shifts one bit position per clock.
- Provides the opposite-direction operations to the combinational datapath shifter (SLL/SRA/ROR): logical right shift, left shift, and rotate left.
- Sits beside the ALU as a handshaked execution unit. Decode issues a request on the input side; writeback consumes the result on the output side.

Parameters:
- WIDTH, 16, data width of operand and result.
- SHAMT_W, 4, number of low bits of b used as the shift amount.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- opcode  input  2  operation: 00 SRL, 01 SLL, 10 ROL, 11 pass-through.
- a  input  WIDTH  operand (rs).
- b  input  WIDTH  shift amount source (rt/imm). Only b[SHAMT_W-1:0] is used.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  shifted value (rd).
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. It is sampled on the rising edge of clk; asynchronous reset is not used.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, internal work register=0, count=0, latched op=00.
- Reset mid-operation: at the next edge the state returns to IDLE and any in-flight request is discarded. No out_valid pulse is produced for it.
- States: IDLE, SHIFT, DONE. State is encoded in a register; outputs are decoded from state, so no combinational input-to-output paths exist.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch op=opcode, work=a, count=b[SHAMT_W-1:0].
  - If count==0 or opcode==11, go to DONE. Otherwise go to SHIFT.
- SHIFT: in_ready=0, busy=1. Each cycle, work is updated per op:
  - SRL: work = {1'b0, work[WIDTH-1:1]}.
  - SLL: work = {work[WIDTH-2:0], 1'b0}.
  - ROL: work = {work[WIDTH-2:0], work[WIDTH-1]}.
  - count decrements by 1 each cycle. When count==1, the final shift is performed and the next state is DONE.
- DONE:
  - out_valid=1 and result=work. result is registered and stable while out_valid=1.
  - If out_ready=1, go to IDLE next edge; out_valid drops and in_ready rises in the same cycle.
  - If out_ready=0, hold DONE and result indefinitely.
- Latency: out_valid rises exactly shamt+1 rising edges after the accept edge, where shamt=b[SHAMT_W-1:0]. For opcode 11, latency is 1 regardless of shamt.
- Throughput: one request in flight. A new request is accepted only in IDLE, so the minimum spacing between accepts is shamt+2 cycles.
- Ignored inputs while not in IDLE: in_valid, opcode, a and b. A request presented then stays pending upstream until in_ready=1.
- out_ready is ignored while out_valid=0.
- Width rules: shift amount is unsigned and ranges 0..15. b[WIDTH-1:SHAMT_W] is ignored. There is no carry or flag output.
- Shift of 15: SRL and SLL leave at most one original bit. ROL by 15 equals ROR by 1.

Test Plan:
- SRL: opcode=00, a=0x8001, b=0x0004 -> out_valid rises 5 edges after accept, result=0x0800. Confirm no sign fill.
- ROL: opcode=10, a=0x8001, b=0x0001 -> result=0x0003 after 2 edges. ROL with a=0x1234, b=0x000F -> result=0x091A.
- SLL: opcode=01, a=0x00F0, b=0xFFF8 -> upper bits of b are ignored, result=0xF000 after 9 edges.
- Zero shift and pass-through:
  - opcode=00, a=0xBEEF, b=0 -> result=0xBEEF after 1 edge.
  - opcode=11, a=0x1234, b=0x000F -> result=0x1234 after 1 edge.
- Backpressure: complete an SRL with out_ready=0 for 3 cycles while in_valid=1 with new operands -> result is held, in_ready=0, and the new request is not accepted. Raise out_ready -> IDLE next edge, then the new request is accepted.
- Reset mid-SHIFT: opcode=01, a=0x0001, b=0x000A; assert rst_n=0 for 1 cycle at cycle 4 -> next edge state=IDLE, result=0x0000, out_valid never pulses, in_ready=1.
